// File: rtl/nibble_serial_addsub_if.sv
// Command/result bundle between a command source and the nibble-serial add/sub sequencer.
// The master drives the operands and start; the slave returns the status and the result.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c;
    logic         v;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, c, v
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, c, v
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract through one 4-bit stage, one nibble per cycle LSB first; optional V via NIBBLE_SERIAL_OVF_DETECT_EN.
// Latency NIBBLES cycles accept-to-done; start is accepted in IDLE or DONE and ignored while busy.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_addsub_if.slave bus
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CW-1:0]            cnt;
    logic                     carry;
    logic [NIBBLES-1:0][3:0]  a_q;
    logic [NIBBLES-1:0][3:0]  b_q;
    logic [NIBBLES-1:0][3:0]  s_q;
    logic                     sub_q;
    logic                     c_q;
    logic                     accept;
    logic                     last;
    logic [3:0]               a_nib;
    logic [3:0]               b_nib;
    logic [4:0]               sum;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(NIBBLES - 1));

    // The shared narrow stage: B is inverted for subtract, carry seeded with sub.
    assign a_nib = a_q[cnt];
    assign b_nib = b_q[cnt] ^ {4{sub_q}};
    assign sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            sub_q <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            c_q   <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sub_q <= bus.sub;
            cnt   <= '0;
            carry <= bus.sub;
        end else if (state == RUN) begin
            s_q[cnt] <= sum[3:0];
            carry    <= sum[4];
            cnt      <= cnt + 1'b1;
            if (last) begin
                c_q <= sum[4];
            end
        end
    end

    assign bus.s = s_q;
    assign bus.c = c_q;

`ifdef NIBBLE_SERIAL_OVF_DETECT_EN
    logic v_q;

    // Overflow = carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if ((state == RUN) && last && !accept) begin
            v_q <= (a_nib[3] ^ b_nib[3] ^ sum[3]) ^ sum[4];
        end
    end

    assign bus.v = v_q;
`else
    assign bus.v = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub: spec vectors, handshake and reset corners, random ops vs. an arithmetic model.
module tb_nibble_serial_addsub;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
`ifdef NIBBLE_SERIAL_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic v);
        longint ua, ub, us, sa, sb, sr;
        longint mx, mn;
        ua = longint'(a);
        ub = longint'(b);
        sa = (a[W-1]) ? ua - (longint'(1) << W) : ua;
        sb = (b[W-1]) ? ub - (longint'(1) << W) : ub;
        mx = (longint'(1) << (W - 1)) - 1;
        mn = -(longint'(1) << (W - 1));
        if (sub) begin
            us = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            us = ua + ub;
            sr = sa + sb;
            c  = (us >= (longint'(1) << W));
        end
        s = W'(us);
        v = OVF_EN && ((sr > mx) || (sr < mn));
    endtask

    // One operation: accept, optional start poke while busy, exact done timing, result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input bit poke, input string tag);
        logic [W-1:0] es;
        logic         ec, ev;
        model(a, b, sub, es, ec, ev);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        check({tag, " busy@accept"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= NIBBLES; k++) begin
            @(negedge clk);
            bus.start = poke && (k == 1);
            bus.a     = W'($urandom());
            bus.b     = W'($urandom());
            bus.sub   = 1'($urandom());
            @(posedge clk);
            #1;
            if (k == 1) check({tag, " nibble0"}, 32'(bus.s[3:0]), 32'(es[3:0]));
            if (k < NIBBLES) begin
                check({tag, " done early"}, 32'(bus.done), 32'd0);
            end else begin
                check({tag, " done"}, 32'(bus.done), 32'd1);
                check({tag, " busy@done"}, 32'(bus.busy), 32'd0);
                check({tag, " S"}, 32'(bus.s), 32'(es));
                check({tag, " C"}, 32'(bus.c), 32'(ec));
                check({tag, " V"}, 32'(bus.v), 32'(ev));
            end
        end
        bus.start = 1'b0;
    endtask

    vec_t vecs[8];
    int   done_seen;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};

        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset S", 32'(bus.s), 32'd0);
        check("reset C", 32'(bus.c), 32'd0);
        check("reset V", 32'(bus.v), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Fixed vectors: the model must agree with the hand-derived table, then the DUT with both.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ms;
            logic         mc, mv;
            model(vecs[i].a, vecs[i].b, vecs[i].sub, ms, mc, mv);
            check($sformatf("table%0d model S", i), 32'(ms), 32'(vecs[i].s));
            check($sformatf("table%0d model C", i), 32'(mc), 32'(vecs[i].c));
            check($sformatf("table%0d model V", i), 32'(mv), 32'(OVF_EN && vecs[i].v));
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b0, $sformatf("table%0d", i));
            repeat (1) @(posedge clk);
        end

        // start pulsed while busy must not disturb result or timing.
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b1, "poke");
        repeat (2) @(posedge clk);

        // Back-to-back: second op accepted in the DONE cycle, done 5 cycles after the first.
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0, "b2b first");
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "b2b second");
        repeat (2) @(posedge clk);

        // Reset in the middle of an add.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0FFF;
        bus.sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        check("midrun busy before rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun rst busy", 32'(bus.busy), 32'd0);
        check("midrun rst done", 32'(bus.done), 32'd0);
        check("midrun rst S", 32'(bus.s), 32'd0);
        check("midrun rst C", 32'(bus.c), 32'd0);
        check("midrun rst V", 32'(bus.v), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        check("midrun no done", 32'(done_seen), 32'd0);
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "after reset");

        // Random operations against the model, with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom());
            rb = W'($urandom());
            rs = 1'($urandom());
            if (i % 8 == 0) rb = ra;
            run_op(ra, rb, rs, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
